// File: rtl/recharge.sv
// Card top-up: edits a 3-digit BCD amount, adds it digit by digit to the signed-BCD
// balance (999 saturation, debt repayment), writes it back and shows it on the display.
module recharge #(
   parameter int unsigned BLINK_CYC = 32'd50_000_000,
   parameter int unsigned SHOW_CYC  = 32'd100_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        on,
   input  logic [15:0] bal,
   input  logic        u_pos,
   input  logic        d_pos,
   input  logic        m_pos,
   input  logic        c_pos,
   output logic [3:0]  n0,
   output logic [3:0]  n3,
   output logic [3:0]  n2,
   output logic [3:0]  n1,
   output logic [15:0] new_bal,
   output logic        bal_we,
   output logic        sat,
   output logic        busy,
   output logic        beep
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EDIT = 2'd1,
      S_ADD  = 2'd2,
      S_SHOW = 2'd3
   } state_t;

   localparam logic [3:0]  SGN_NEG    = 4'd10;
   localparam logic [3:0]  BLANK      = 4'd11;
   localparam logic [31:0] BLINK_HALF = 32'(BLINK_CYC);
   localparam logic [31:0] BLINK_LAST = 32'(32'd2 * BLINK_CYC - 32'd1);
   localparam logic [31:0] SHOW_LAST  = 32'(SHOW_CYC - 32'd1);
   localparam logic [31:0] BEEP_LEN   = 32'(SHOW_CYC / 32'd4);

   function automatic logic [3:0] dig_inc(input logic [3:0] d);
      if (d >= 4'd9) return 4'd0;
      else return d + 4'd1;
   endfunction

   function automatic logic [3:0] dig_dec(input logic [3:0] d);
      if (d == 4'd0) return 4'd9;
      else return d - 4'd1;
   endfunction

   // Returns {carry, digit}.
   function automatic logic [4:0] dig_add(input logic [3:0] a, input logic [3:0] b, input logic ci);
      logic [4:0] s;
      s = {1'b0, a} + {1'b0, b} + {4'd0, ci};
      if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
      else return {1'b0, s[3:0]};
   endfunction

   // Returns {borrow, digit}.
   function automatic logic [4:0] dig_sub(input logic [3:0] a, input logic [3:0] b, input logic bi);
      logic [4:0] need;
      logic [4:0] s;
      need = {1'b0, b} + {4'd0, bi};
      if ({1'b0, a} < need) begin
         s = {1'b0, a} + 5'd10 - need;
         return {1'b1, s[3:0]};
      end else begin
         s = {1'b0, a} - need;
         return {1'b0, s[3:0]};
      end
   endfunction

   function automatic logic [3:0] dsel(input logic [11:0] v, input logic [1:0] i);
      case (i)
         2'd0:    return v[3:0];
         2'd1:    return v[7:4];
         default: return v[11:8];
      endcase
   endfunction

   function automatic logic [11:0] dput(input logic [11:0] v, input logic [1:0] i, input logic [3:0] d);
      logic [11:0] r;
      r = v;
      case (i)
         2'd0:    r[3:0]  = d;
         2'd1:    r[7:4]  = d;
         default: r[11:8] = d;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] sign_code(input logic [3:0] s);
      if (s == SGN_NEG) return SGN_NEG;
      else return BLANK;
   endfunction

   state_t      state_r, state_s;
   logic [2:0]  step_r, step_s;
   logic [11:0] amt_r, amt_s;
   logic [1:0]  cursor_r, cursor_s;
   logic [31:0] blink_r, blink_s;
   logic [31:0] show_r, show_s;
   logic [15:0] hold_r, hold_s;
   logic [11:0] opa_r, opa_s;
   logic [11:0] opb_r, opb_s;
   logic [11:0] res_r, res_s;
   logic        sub_r, sub_s;
   logic        neg_r, neg_s;
   logic        cy_r, cy_s;
   logic [3:0]  n0_r, n0_s, n3_r, n3_s, n2_r, n2_s, n1_r, n1_s;
   logic [15:0] new_bal_r, new_bal_s;
   logic        bal_we_r, bal_we_s;
   logic        sat_r, sat_s;
   logic        busy_r, busy_s;
   logic        beep_r, beep_s;
   logic [1:0]  di_s;
   logic [4:0]  dig_s;

   // Next-state, BCD datapath and display decode.
   always_comb begin
      state_s   = state_r;
      step_s    = step_r;
      amt_s     = amt_r;
      cursor_s  = cursor_r;
      blink_s   = blink_r;
      show_s    = show_r;
      hold_s    = hold_r;
      opa_s     = opa_r;
      opb_s     = opb_r;
      res_s     = res_r;
      sub_s     = sub_r;
      neg_s     = neg_r;
      cy_s      = cy_r;
      new_bal_s = new_bal_r;
      sat_s     = sat_r;
      bal_we_s  = 1'b0;
      di_s      = 2'd0;
      dig_s     = 5'd0;
      if (!on) begin
         state_s  = S_IDLE;
         step_s   = 3'd0;
         amt_s    = 12'd0;
         cursor_s = 2'd0;
         blink_s  = 32'd0;
         show_s   = 32'd0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (m_pos) begin
                  state_s  = S_EDIT;
                  amt_s    = 12'd0;
                  cursor_s = 2'd0;
                  blink_s  = 32'd0;
               end else begin
                  state_s = S_IDLE;
               end
            end
            S_EDIT: begin
               if (c_pos) begin
                  if (amt_r == 12'd0) begin
                     state_s  = S_IDLE;
                     cursor_s = 2'd0;
                     blink_s  = 32'd0;
                  end else begin
                     state_s = S_ADD;
                     step_s  = 3'd0;
                     hold_s  = bal;
                  end
               end else if (m_pos) begin
                  cursor_s = (cursor_r >= 2'd2) ? 2'd0 : cursor_r + 2'd1;
                  blink_s  = 32'd0;
               end else if (u_pos) begin
                  amt_s   = dput(amt_r, cursor_r, dig_inc(dsel(amt_r, cursor_r)));
                  blink_s = 32'd0;
               end else if (d_pos) begin
                  amt_s   = dput(amt_r, cursor_r, dig_dec(dsel(amt_r, cursor_r)));
                  blink_s = 32'd0;
               end else begin
                  blink_s = (blink_r >= BLINK_LAST) ? 32'd0 : blink_r + 32'd1;
               end
            end
            S_ADD: begin
               case (step_r)
                  3'd0: begin
                     // Order operands so subtraction never borrows out of the hundreds.
                     if (hold_r[15:12] != SGN_NEG) begin
                        opa_s = hold_r[11:0];
                        opb_s = amt_r;
                        sub_s = 1'b0;
                        neg_s = 1'b0;
                     end else if (amt_r >= hold_r[11:0]) begin
                        opa_s = amt_r;
                        opb_s = hold_r[11:0];
                        sub_s = 1'b1;
                        neg_s = 1'b0;
                     end else begin
                        opa_s = hold_r[11:0];
                        opb_s = amt_r;
                        sub_s = 1'b1;
                        neg_s = 1'b1;
                     end
                     cy_s   = 1'b0;
                     res_s  = 12'd0;
                     step_s = 3'd1;
                  end
                  3'd1, 3'd2, 3'd3: begin
                     di_s = step_r[1:0] - 2'd1;
                     if (sub_r) begin
                        dig_s = dig_sub(dsel(opa_r, di_s), dsel(opb_r, di_s), cy_r);
                     end else begin
                        dig_s = dig_add(dsel(opa_r, di_s), dsel(opb_r, di_s), cy_r);
                     end
                     res_s  = dput(res_r, di_s, dig_s[3:0]);
                     cy_s   = dig_s[4];
                     step_s = step_r + 3'd1;
                  end
                  3'd4: begin
                     bal_we_s = 1'b1;
                     state_s  = S_SHOW;
                     show_s   = 32'd0;
                     step_s   = 3'd0;
                     if (!sub_r && cy_r) begin
                        new_bal_s = {4'd0, 12'h999};
                        sat_s     = 1'b1;
                     end else begin
                        sat_s = 1'b0;
                        if (neg_r && (res_r != 12'd0)) new_bal_s = {SGN_NEG, res_r};
                        else new_bal_s = {4'd0, res_r};
                     end
                  end
                  default: begin
                     state_s = S_IDLE;
                     step_s  = 3'd0;
                  end
               endcase
            end
            S_SHOW: begin
               if (m_pos) begin
                  state_s = S_IDLE;
                  show_s  = 32'd0;
               end else if (show_r >= SHOW_LAST) begin
                  state_s = S_IDLE;
                  show_s  = 32'd0;
               end else begin
                  show_s = show_r + 32'd1;
               end
            end
            default: begin
               state_s = S_IDLE;
            end
         endcase
      end

      busy_s = (state_s != S_IDLE);
      beep_s = (state_s == S_SHOW) && (show_s < BEEP_LEN);

      n0_s = BLANK;
      n3_s = BLANK;
      n2_s = BLANK;
      n1_s = BLANK;
      case (state_s)
         S_IDLE: begin
            n0_s = sign_code(bal[15:12]);
            n3_s = bal[11:8];
            n2_s = bal[7:4];
            n1_s = bal[3:0];
         end
         S_EDIT: begin
            n3_s = amt_s[11:8];
            n2_s = amt_s[7:4];
            n1_s = amt_s[3:0];
            if (blink_s >= BLINK_HALF) begin
               case (cursor_s)
                  2'd0:    n1_s = BLANK;
                  2'd1:    n2_s = BLANK;
                  default: n3_s = BLANK;
               endcase
            end else begin
               n0_s = BLANK;
            end
         end
         S_ADD: begin
            n3_s = amt_r[11:8];
            n2_s = amt_r[7:4];
            n1_s = amt_r[3:0];
         end
         S_SHOW: begin
            n0_s = sign_code(new_bal_s[15:12]);
            n3_s = new_bal_s[11:8];
            n2_s = new_bal_s[7:4];
            n1_s = new_bal_s[3:0];
         end
         default: begin
            n0_s = BLANK;
         end
      endcase
   end

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= S_IDLE;
         step_r    <= 3'd0;
         amt_r     <= 12'd0;
         cursor_r  <= 2'd0;
         blink_r   <= 32'd0;
         show_r    <= 32'd0;
         hold_r    <= 16'd0;
         opa_r     <= 12'd0;
         opb_r     <= 12'd0;
         res_r     <= 12'd0;
         sub_r     <= 1'b0;
         neg_r     <= 1'b0;
         cy_r      <= 1'b0;
         n0_r      <= BLANK;
         n3_r      <= BLANK;
         n2_r      <= BLANK;
         n1_r      <= BLANK;
         new_bal_r <= 16'd0;
         bal_we_r  <= 1'b0;
         sat_r     <= 1'b0;
         busy_r    <= 1'b0;
         beep_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         step_r    <= step_s;
         amt_r     <= amt_s;
         cursor_r  <= cursor_s;
         blink_r   <= blink_s;
         show_r    <= show_s;
         hold_r    <= hold_s;
         opa_r     <= opa_s;
         opb_r     <= opb_s;
         res_r     <= res_s;
         sub_r     <= sub_s;
         neg_r     <= neg_s;
         cy_r      <= cy_s;
         n0_r      <= n0_s;
         n3_r      <= n3_s;
         n2_r      <= n2_s;
         n1_r      <= n1_s;
         new_bal_r <= new_bal_s;
         bal_we_r  <= bal_we_s;
         sat_r     <= sat_s;
         busy_r    <= busy_s;
         beep_r    <= beep_s;
      end
   end

   assign n0      = n0_r;
   assign n3      = n3_r;
   assign n2      = n2_r;
   assign n1      = n1_r;
   assign new_bal = new_bal_r;
   assign bal_we  = bal_we_r;
   assign sat     = sat_r;
   assign busy    = busy_r;
   assign beep    = beep_r;

endmodule

// File: tb/tb_recharge.sv
// Directed plus randomized bench for recharge; expected balances come from an
// integer model of the top-up rules, edit digits from a small digit/cursor model.
module tb_recharge;
   logic        clk = 1'b0;
   logic        rst, on;
   logic [15:0] bal;
   logic        u_pos, d_pos, m_pos, c_pos;
   logic [3:0]  n0, n3, n2, n1;
   logic [15:0] new_bal;
   logic        bal_we, sat, busy, beep;

   int checks = 0;
   int errors = 0;
   int amt_m[3];
   int cur_m;

   recharge #(.BLINK_CYC(4), .SHOW_CYC(8)) dut (
      .clk(clk), .rst(rst), .on(on), .bal(bal),
      .u_pos(u_pos), .d_pos(d_pos), .m_pos(m_pos), .c_pos(c_pos),
      .n0(n0), .n3(n3), .n2(n2), .n1(n1),
      .new_bal(new_bal), .bal_we(bal_we), .sat(sat), .busy(busy), .beep(beep)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int amt_val();
      return amt_m[2] * 100 + amt_m[1] * 10 + amt_m[0];
   endfunction

   // {sat, new_bal} from signed integer arithmetic.
   function automatic logic [16:0] model_add(input logic [15:0] b, input int a);
      int mag, v, r, m;
      logic s;
      logic [15:0] o;
      mag = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
      v = (b[15:12] == 4'd10) ? -mag : mag;
      r = v + a;
      s = 1'b0;
      if (r > 999) begin
         r = 999;
         s = 1'b1;
      end
      m = (r < 0) ? -r : r;
      o[15:12] = (r < 0) ? 4'd10 : 4'd0;
      o[11:8]  = 4'(m / 100);
      o[7:4]   = 4'((m / 10) % 10);
      o[3:0]   = 4'(m % 10);
      return {s, o};
   endfunction

   function automatic logic [15:0] idle_disp(input logic [15:0] b);
      return {(b[15:12] == 4'd10) ? 4'd10 : 4'd11, b[11:0]};
   endfunction

   function automatic logic [11:0] amt_disp();
      return {4'(amt_m[2]), 4'(amt_m[1]), 4'(amt_m[0])};
   endfunction

   task automatic enter_edit();
      m_pos = 1'b1; tick(); m_pos = 1'b0;
      amt_m = '{0, 0, 0};
      cur_m = 0;
      chk("edit_busy", busy, 1'b1);
      chk("edit_entry_disp", {n0, n3, n2, n1}, 16'hB000);
   endtask

   task automatic press(input logic pu, input logic pd, input logic pm);
      u_pos = pu; d_pos = pd; m_pos = pm;
      tick();
      u_pos = 1'b0; d_pos = 1'b0; m_pos = 1'b0;
      if (pm) cur_m = (cur_m + 1) % 3;
      else if (pu) amt_m[cur_m] = (amt_m[cur_m] + 1) % 10;
      else if (pd) amt_m[cur_m] = (amt_m[cur_m] + 9) % 10;
      chk("edit_disp", {n3, n2, n1}, amt_disp());
   endtask

   task automatic set_amount(input int a);
      int d[3];
      d[0] = a % 10; d[1] = (a / 10) % 10; d[2] = a / 100;
      enter_edit();
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < d[k]; j++) press(1'b1, 1'b0, 1'b0);
         press(1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic confirm(input string tag, input logic with_u, input bit mess, input bit abort);
      logic [16:0] e;
      int lat;
      bit seen;
      e = model_add(bal, amt_val());
      c_pos = 1'b1; u_pos = with_u;
      tick();
      c_pos = 1'b0; u_pos = 1'b0;
      chk({tag, "_busy"}, busy, 1'b1);
      if (mess) bal = 16'($urandom);
      lat = 0; seen = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (!seen) begin
            tick();
            if (bal_we === 1'b1) begin
               seen = 1'b1;
               lat = i;
            end
         end
      end
      chk({tag, "_latency"}, lat, 5);
      chk({tag, "_new_bal"}, new_bal, e[15:0]);
      chk({tag, "_sat"}, sat, e[16]);
      if (abort) begin
         m_pos = 1'b1; tick(); m_pos = 1'b0;
         chk({tag, "_show_abort"}, busy, 1'b0);
         tick();
         chk({tag, "_no_reedit"}, busy, 1'b0);
      end else begin
         for (int i = 0; i < 10; i++) begin
            chk({tag, "_show_we"}, bal_we, (i == 0) ? 1'b1 : 1'b0);
            chk({tag, "_show_beep"}, beep, (i < 2) ? 1'b1 : 1'b0);
            chk({tag, "_show_busy"}, busy, (i < 8) ? 1'b1 : 1'b0);
            if (i < 8) chk({tag, "_show_disp"}, {n0, n3, n2, n1}, idle_disp(e[15:0]));
            tick();
         end
      end
   endtask

   task automatic no_write_watch(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bal_we !== 1'b0) seen = 1'b1;
      end
      chk(tag, seen, 1'b0);
   endtask

   initial begin
      logic [2:0] msk;
      rst = 1'b0; on = 1'b1; bal = 16'h0196;
      u_pos = 1'b0; d_pos = 1'b0; m_pos = 1'b0; c_pos = 1'b0;
      tick(); tick();
      chk("rst_disp", {n0, n3, n2, n1}, 16'hBBBB);
      chk("rst_outs", {new_bal, bal_we, sat, busy, beep}, 20'h0);

      rst = 1'b1;
      tick();
      chk("idle_disp", {n0, n3, n2, n1}, idle_disp(bal));
      u_pos = 1'b1; c_pos = 1'b1; tick(); u_pos = 1'b0; c_pos = 1'b0;
      chk("idle_ignore", busy, 1'b0);

      // 196 + 15
      set_amount(15);
      confirm("add196_15", 1'b0, 1'b0, 1'b0);
      // 990 + 20 saturates
      bal = 16'h0990; tick();
      set_amount(20);
      confirm("sat990_20", 1'b0, 1'b0, 1'b1);
      // debt cases, with bal changed after confirm to prove it is not re-read
      bal = 16'hA028; tick();
      set_amount(10);
      confirm("debt_10", 1'b0, 1'b1, 1'b1);
      bal = 16'hA028; tick();
      set_amount(28);
      confirm("debt_28", 1'b0, 1'b1, 1'b1);
      bal = 16'hA028; tick();
      set_amount(100);
      confirm("debt_100", 1'b0, 1'b1, 1'b1);

      // digit wrap, no carry into tens, c beats u
      bal = 16'h0100; tick();
      enter_edit();
      press(1'b0, 1'b0, 1'b1);
      repeat (3) press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      press(1'b0, 1'b0, 1'b1);
      press(1'b0, 1'b1, 1'b0);
      chk("wrap_dn", {n2, n1}, 8'h39);
      press(1'b1, 1'b0, 1'b0);
      chk("wrap_up", {n2, n1}, 8'h30);
      confirm("c_over_u", 1'b1, 1'b0, 1'b1);

      // confirm with zero amount
      enter_edit();
      c_pos = 1'b1; tick(); c_pos = 1'b0;
      chk("zero_amt_idle", busy, 1'b0);
      no_write_watch("zero_amt_no_we");

      // blink on tens digit
      enter_edit();
      repeat (2) press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      repeat (7) press(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) begin
         chk("blink_n2", n2, ((k % 8) < 4) ? 4'd7 : 4'd11);
         chk("blink_steady", {n0, n3, n1}, 12'hB02);
         tick();
      end

      // power off during edit
      on = 1'b0; tick();
      chk("off_busy", busy, 1'b0);
      chk("off_disp", {n0, n3, n2, n1}, idle_disp(bal));
      on = 1'b1; tick();
      enter_edit();
      press(1'b0, 1'b0, 1'b1);
      chk("off_amt_clear", {n3, n2, n1}, 12'h000);
      m_pos = 1'b1; tick(); m_pos = 1'b0;
      m_pos = 1'b1; tick(); m_pos = 1'b0;
      c_pos = 1'b1; tick(); c_pos = 1'b0;

      // reset during A2
      set_amount(123);
      c_pos = 1'b1; tick(); c_pos = 1'b0;
      tick(); tick();
      rst = 1'b0; tick();
      chk("midrst_disp", {n0, n3, n2, n1}, 16'hBBBB);
      chk("midrst_outs", {new_bal, bal_we, sat, busy, beep}, 20'h0);
      rst = 1'b1;
      no_write_watch("midrst_no_we");

      // randomized edits against the digit and arithmetic models
      for (int it = 0; it < 15; it++) begin
         bal = {($urandom_range(0, 1) == 1) ? 4'd10 : 4'd0,
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         tick();
         chk("rnd_idle_disp", {n0, n3, n2, n1}, idle_disp(bal));
         enter_edit();
         for (int j = 0; j < 10; j++) begin
            msk = 3'($urandom);
            if (msk == 3'd0) msk = 3'b100;
            press(msk[2], msk[1], msk[0]);
         end
         if (amt_val() == 0) begin
            c_pos = 1'b1; tick(); c_pos = 1'b0;
            chk("rnd_zero_idle", busy, 1'b0);
         end else begin
            confirm("rnd", 1'b0, 1'b1, 1'b0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
